// File: rtl/prio_arbiter_pkg.sv
// Shared types and helpers for the prio_arbiter block.
// Optional feature macro used by the top: PRIO_ARBITER_RR_EN (rotating priority).
package prio_arbiter_pkg;

   // Arbiter FSM: waiting for requests, or presenting a grant.
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int DEFAULT_N = 8;

   // Ceiling log2, used for index widths (clog2(8)=3, clog2(5)=3, clog2(2)=1).
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < v) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/prio_arbiter_enc.sv
// prio_enc_comb: purely combinational highest-set-bit encoder (N lines -> W-bit index + any).
module prio_enc_comb
   import prio_arbiter_pkg::*;
#(
   parameter int N = DEFAULT_N,
   parameter int W = clog2(N)
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         any
);

   // Ascending scan: the last set bit seen is the highest, so it wins.
   always_comb begin
      idx = '0;
      any = |req;
      for (int i = 0; i < N; i++) begin
         if (req[i]) idx = W'(i);
      end
   end

endmodule

// File: rtl/prio_arbiter.sv
// prio_arbiter: N-input registered priority arbiter with valid/ready grant handshake.
// Fixed priority (highest index wins) by default; define PRIO_ARBITER_RR_EN for
// rotating priority, where the search starts just below the last accepted grant.
module prio_arbiter
   import prio_arbiter_pkg::*;
#(
   parameter  int N = DEFAULT_N,
   localparam int W = clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [W-1:0] gnt_idx,
   output logic [N-1:0] gnt_oh,
   output logic         gnt_valid,
   input  logic         gnt_ready
);

   state_t         state_reg, state_next;
   logic [W-1:0]   idx_reg, idx_next;
   logic [N-1:0]   oh_reg, oh_next;
   logic           valid_reg, valid_next;

   logic           hs;
   logic           load;
   logic [W-1:0]   win_idx;
   logic           win_any;

   // Handshake retires the current grant; IDLE or a handshake lets a new winner load.
   assign hs   = (state_reg == GRANT) & gnt_ready;
   assign load = (state_reg == IDLE) | hs;

`ifdef PRIO_ARBITER_RR_EN
   logic [W-1:0]   last_reg, last_next;
   logic [W-1:0]   search_last;
   logic [N-1:0]   mask;
   logic [N-1:0]   req_masked;
   logic [W-1:0]   m_idx, u_idx;
   logic           m_any, u_any;

   // On a handshake the grant being retired already counts as "last", so a
   // back-to-back winner rotates away from it on the same edge.
   assign search_last = hs ? idx_reg : last_reg;
   assign last_next   = hs ? idx_reg : last_reg;

   // Lines strictly below last are searched first; if none request, fall back
   // to the full vector, which yields the wrap to N-1 .. last.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_mask
         assign mask[gi] = (W'(gi) < search_last);
      end
   endgenerate

   assign req_masked = req & mask;

   prio_enc_comb #(.N(N), .W(W)) u_enc_masked (
      .req (req_masked),
      .idx (m_idx),
      .any (m_any)
   );

   prio_enc_comb #(.N(N), .W(W)) u_enc_full (
      .req (req),
      .idx (u_idx),
      .any (u_any)
   );

   assign win_idx = m_any ? m_idx : u_idx;
   assign win_any = u_any;

   // Rotation pointer, updated only when a grant is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_reg <= '0;
      else        last_reg <= last_next;
   end
`else
   prio_enc_comb #(.N(N), .W(W)) u_enc (
      .req (req),
      .idx (win_idx),
      .any (win_any)
   );
`endif

   // Next-state and next-output logic; the grant is frozen unless a load is allowed.
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      oh_next    = oh_reg;
      valid_next = valid_reg;
      if (load) begin
         if (win_any) begin
            state_next       = GRANT;
            valid_next       = 1'b1;
            idx_next         = win_idx;
            oh_next          = '0;
            oh_next[win_idx] = 1'b1;
         end else begin
            state_next = IDLE;
            valid_next = 1'b0;
            idx_next   = '0;
            oh_next    = '0;
         end
      end
   end

   // State and grant registers; reset drops any pending grant immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         oh_reg    <= '0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         oh_reg    <= oh_next;
         valid_reg <= valid_next;
      end
   end

   assign gnt_idx   = idx_reg;
   assign gnt_oh    = oh_reg;
   assign gnt_valid = valid_reg;

endmodule

// File: tb/tb_prio_arbiter.sv
// Testbench for prio_arbiter (N=8 main instance, N=5 secondary instance).
// Expectations follow PRIO_ARBITER_RR_EN when the bench is compiled with it.
module tb_prio_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic       gnt_ready;
   logic [2:0] gnt_idx;
   logic [7:0] gnt_oh;
   logic       gnt_valid;

   logic [4:0] req5;
   logic       ready5;
   logic [2:0] idx5;
   logic [4:0] oh5;
   logic       valid5;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model state for the N=8 instance.
   bit         m_valid;
   int         m_idx;
   int         m_last;
   logic [7:0] m_oh;

   always #5 clk = ~clk;

   prio_arbiter #(.N(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt_idx   (gnt_idx),
      .gnt_oh    (gnt_oh),
      .gnt_valid (gnt_valid),
      .gnt_ready (gnt_ready)
   );

   prio_arbiter #(.N(5)) dut5 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req5),
      .gnt_idx   (idx5),
      .gnt_oh    (oh5),
      .gnt_valid (valid5),
      .gnt_ready (ready5)
   );

   // Winner from the priority rule: rotating search last-1 .. 0, n-1 .. last,
   // or simply the highest requesting line in fixed mode.
   function automatic int winner(input logic [63:0] r, input int last, input int n);
`ifdef PRIO_ARBITER_RR_EN
      for (int k = 1; k <= n; k++) begin
         int i;
         i = (last - k + n) % n;
         if (r[i]) return i;
      end
      return 0;
`else
      for (int i = n - 1; i >= 0; i--) begin
         if (r[i]) return i;
      end
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_idx   = 0;
      m_last  = 0;
      m_oh    = 8'h00;
   endtask

   // Advance the model by one clock edge using the inputs presented to that edge.
   task automatic model_step();
      if (!m_valid || gnt_ready) begin
         if (m_valid) m_last = m_idx;
         if (req != 8'h00) begin
            m_valid = 1'b1;
            m_idx   = winner(64'(req), m_last, 8);
         end else begin
            m_valid = 1'b0;
            m_idx   = 0;
         end
      end
      m_oh = m_valid ? (8'h01 << m_idx) : 8'h00;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req       = 8'h00;
      gnt_ready = 1'b0;
      req5      = 5'h00;
      ready5    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req       = 8'h00;
      gnt_ready = 1'b0;
      req5      = 5'h00;
      ready5    = 1'b0;
      model_reset();
      #1;
      tests_run++;
      if ({gnt_valid, gnt_idx, gnt_oh} !== 12'h000) begin
         tests_failed++;
         $display("FAIL reset_hold: got v=%0b idx=%0d oh=%h, exp v=0 idx=0 oh=00", gnt_valid, gnt_idx, gnt_oh);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         tests_run++;
         if ({gnt_valid, gnt_idx, gnt_oh} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_idle c%0d: got v=%0b idx=%0d oh=%h, exp v=0 idx=0 oh=00", c, gnt_valid, gnt_idx, gnt_oh);
         end
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_basic();
      req       = 8'h81;
      gnt_ready = 1'b1;
      step();
      tests_run++;
      if ({gnt_valid, gnt_idx, gnt_oh} !== {1'b1, 3'd7, 8'h80}) begin
         tests_failed++;
         $display("FAIL basic_81: got v=%0b idx=%0d oh=%h, exp v=1 idx=7 oh=80", gnt_valid, gnt_idx, gnt_oh);
      end
      req = 8'h00;
      step();
      tests_run++;
      if ({gnt_valid, gnt_idx, gnt_oh} !== 12'h000) begin
         tests_failed++;
         $display("FAIL basic_release: got v=%0b idx=%0d oh=%h, exp v=0 idx=0 oh=00", gnt_valid, gnt_idx, gnt_oh);
      end
      $display("[TB] test_basic done");
   endtask

   task automatic test_hold();
      req       = 8'h0A;
      gnt_ready = 1'b0;
      step();
      tests_run++;
      if ({gnt_valid, gnt_idx, gnt_oh} !== {1'b1, 3'd3, 8'h08}) begin
         tests_failed++;
         $display("FAIL hold_first: got v=%0b idx=%0d oh=%h, exp v=1 idx=3 oh=08", gnt_valid, gnt_idx, gnt_oh);
      end
      req = 8'h40;
      for (int c = 0; c < 4; c++) begin
         step();
         tests_run++;
         if ({gnt_valid, gnt_idx, gnt_oh} !== {1'b1, 3'd3, 8'h08}) begin
            tests_failed++;
            $display("FAIL hold_frozen c%0d: got v=%0b idx=%0d oh=%h, exp v=1 idx=3 oh=08", c, gnt_valid, gnt_idx, gnt_oh);
         end
      end
      gnt_ready = 1'b1;
      step();
      tests_run++;
      if ({gnt_valid, gnt_idx, gnt_oh} !== {1'b1, 3'd6, 8'h40}) begin
         tests_failed++;
         $display("FAIL hold_b2b: got v=%0b idx=%0d oh=%h, exp v=1 idx=6 oh=40", gnt_valid, gnt_idx, gnt_oh);
      end
      req = 8'h00;
      step();
      tests_run++;
      if ({gnt_valid, gnt_idx, gnt_oh} !== 12'h000) begin
         tests_failed++;
         $display("FAIL hold_idle: got v=%0b idx=%0d oh=%h, exp v=0 idx=0 oh=00", gnt_valid, gnt_idx, gnt_oh);
      end
      $display("[TB] test_hold done");
   endtask

   task automatic test_async_reset();
      req       = 8'h01;
      gnt_ready = 1'b0;
      step();
      tests_run++;
      if ({gnt_valid, gnt_idx, gnt_oh} !== {1'b1, 3'd0, 8'h01}) begin
         tests_failed++;
         $display("FAIL arst_grant: got v=%0b idx=%0d oh=%h, exp v=1 idx=0 oh=01", gnt_valid, gnt_idx, gnt_oh);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({gnt_valid, gnt_idx, gnt_oh} !== 12'h000) begin
         tests_failed++;
         $display("FAIL arst_drop: got v=%0b idx=%0d oh=%h, exp v=0 idx=0 oh=00", gnt_valid, gnt_idx, gnt_oh);
      end
      model_reset();
      req = 8'h00;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         tests_run++;
         if ({gnt_valid, gnt_idx, gnt_oh} !== 12'h000) begin
            tests_failed++;
            $display("FAIL arst_idle c%0d: got v=%0b idx=%0d oh=%h, exp v=0 idx=0 oh=00", c, gnt_valid, gnt_idx, gnt_oh);
         end
      end
      $display("[TB] test_async_reset done");
   endtask

   task automatic test_seq_ff();
      int exp_seq [9];
`ifdef PRIO_ARBITER_RR_EN
      exp_seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
`else
      exp_seq = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
`endif
      do_reset();
      req       = 8'hFF;
      gnt_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         step();
         tests_run++;
         if ({gnt_valid, gnt_idx, gnt_oh} !== {1'b1, 3'(exp_seq[k]), 8'(8'h01 << exp_seq[k])}) begin
            tests_failed++;
            $display("FAIL seq_ff k%0d: got v=%0b idx=%0d oh=%h, exp v=1 idx=%0d", k, gnt_valid, gnt_idx, gnt_oh, exp_seq[k]);
         end
      end
      $display("[TB] test_seq_ff done");
   endtask

   task automatic test_seq_81();
      int exp_seq [4];
`ifdef PRIO_ARBITER_RR_EN
      exp_seq = '{7, 0, 7, 0};
`else
      exp_seq = '{7, 7, 7, 7};
`endif
      do_reset();
      req       = 8'h81;
      gnt_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         tests_run++;
         if ({gnt_valid, gnt_idx, gnt_oh} !== {1'b1, 3'(exp_seq[k]), 8'(8'h01 << exp_seq[k])}) begin
            tests_failed++;
            $display("FAIL seq_81 k%0d: got v=%0b idx=%0d oh=%h, exp v=1 idx=%0d", k, gnt_valid, gnt_idx, gnt_oh, exp_seq[k]);
         end
      end
      $display("[TB] test_seq_81 done");
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         req       = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         gnt_ready = ($urandom_range(0, 2) != 0);
         step();
         tests_run++;
         if ({gnt_valid, gnt_idx, gnt_oh} !== {m_valid, 3'(m_idx), m_oh}) begin
            tests_failed++;
            $display("FAIL random c%0d: req=%h got v=%0b idx=%0d oh=%h, exp v=%0b idx=%0d oh=%h",
                     c, req, gnt_valid, gnt_idx, gnt_oh, m_valid, m_idx, m_oh);
         end
      end
      $display("[TB] test_random done");
   endtask

   task automatic test_n5();
      bit         v5;
      int         i5;
      int         l5;
      logic [4:0] o5;
      do_reset();
      v5 = 1'b0;
      i5 = 0;
      l5 = 0;
      for (int c = 0; c < 120; c++) begin
         if (c < 12) begin
            req5   = 5'h1F;
            ready5 = 1'b1;
         end else begin
            req5   = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom);
            ready5 = ($urandom_range(0, 2) != 0);
         end
         if (!v5 || ready5) begin
            if (v5) l5 = i5;
            if (req5 != 5'h00) begin
               v5 = 1'b1;
               i5 = winner(64'(req5), l5, 5);
            end else begin
               v5 = 1'b0;
               i5 = 0;
            end
         end
         o5 = v5 ? 5'(5'h01 << i5) : 5'h00;
         @(posedge clk);
         #1;
         tests_run++;
         if ({valid5, idx5, oh5} !== {v5, 3'(i5), o5} || idx5 > 3'd4) begin
            tests_failed++;
            $display("FAIL n5 c%0d: req=%h got v=%0b idx=%0d oh=%h, exp v=%0b idx=%0d oh=%h",
                     c, req5, valid5, idx5, oh5, v5, i5, o5);
         end
      end
      $display("[TB] test_n5 done");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_async_reset();
      test_seq_ff();
      test_seq_81();
      test_random();
      test_n5();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
